ahbmtx_arb_param: RTL and testbench
===================================

// Module: ahbmtx_arb_param
// PURPOSE
//  Parametrised output-stage arbiter for the AHB bus matrix; one instance per shared slave port.
//  Chooses which of NUM_PORTS input stages drives the slave, and indicates when no port is selected.
//  Adds two things over the fixed 2-port arbiter: selectable fixed-priority or round-robin arbitration,
//  and burst-hold, so a defined-length burst is never split by re-arbitration.
// PARAMETERS
//  NUM_PORTS   4  number of input ports requesting this slave (2..8)
//  PORT_W      3  width of addr_in_port; must satisfy 2**PORT_W >= NUM_PORTS
//  ARB_MODE    0  0 = fixed priority (port 0 highest); 1 = round-robin
//  BURST_HOLD  1  1 = hold grant for the remainder of a defined-length burst; 0 = disabled
// PORTS
//  HCLK          in   1          AHB system clock
//  HRESET        in   1          reset, synchronous, active-high
//  req_port      in   NUM_PORTS  per-port request; bit i = input stage i
//  HREADYM       in   1          slave-side transfer done; every state update qualified by it
//  HSELM         in   1          slave select of the currently muxed address phase
//  HTRANSM       in   2          muxed HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//  HBURSTM       in   3          muxed HBURST
//  HMASTLOCKM    in   1          muxed locked-transfer flag
//  addr_in_port  out  PORT_W     index of the selected input port (registered)
//  no_port       out  1          1 = no input port selected (registered)
//  burst_hold    out  1          1 = grant currently frozen by an in-flight burst (registered)
// BEHAVIOUR
//  Reset (HRESET=1 at a HCLK rising edge):
//   addr_in_port=0, no_port=1, burst_hold=0, beat counter=0, round-robin pointer=0.
//  Registers load only on HCLK rising edges where HREADYM=1; with HREADYM=0 all state holds.
//  Next-state priority (highest first):
//   1. HMASTLOCKM=1: keep current port and current no_port value.
//   2. Burst hold active: keep current port; no_port=0.
//   3. Arbitration:
//      - cand[i] = req_port[i] | (i==addr_in_port & HSELM & HTRANSM!=IDLE & !no_port).
//      - ARB_MODE=0: grant the lowest i with cand[i].
//      - ARB_MODE=1: scan from pointer+1 upward, wrapping modulo NUM_PORTS; grant the first cand.
//        The current port is scanned last unless its cand bit is its only one.
//   4. No cand but HSELM=1: keep current port.
//   5. Otherwise: no_port=1 and addr_in_port holds.
//  Round-robin pointer loads the granted index when a grant is taken in step 3.
//  Beat counter (4 bits), used only when BURST_HOLD=1:
//   - Loads beats-1 on an accepted NONSEQ with HSELM=1 and a fixed-length burst:
//     WRAP4/INCR4 -> 3, WRAP8/INCR8 -> 7, WRAP16/INCR16 -> 15.
//   - SINGLE and INCR load 0 and never hold.
//   - Decrements on each accepted SEQ while nonzero; BUSY does not decrement.
//   - Hold is active while counter != 0. burst_hold registers that condition.
//  Early termination: if IDLE or NONSEQ is accepted while counter != 0, the counter clears
//   in that same update and arbitration proceeds normally in that cycle.
//  Simultaneous events:
//   - Lock beats burst hold.
//   - A NONSEQ that starts a new burst reloads the counter after arbitration. A burst that is
//     granted to a new port does not start counting until that port's NONSEQ is accepted.
//  Request bits must be held by the input stages; one-cycle pulses while HREADYM=0 are lost.
//  HRESET asserted mid-burst: returns immediately to reset values; no hold survives.
//  Request bits at index >= NUM_PORTS do not exist; addr_in_port never exceeds NUM_PORTS-1.
// TESTING
//  T1 Reset: HRESET=1 for 2 cycles -> addr_in_port=0, no_port=1, burst_hold=0.
//  T2 Fixed priority (ARB_MODE=0): req_port=4'b1010 with HREADYM=1 -> addr_in_port=1, no_port=0;
//     then req_port=4'b1000, current port IDLE -> addr_in_port=3.
//  T3 Round-robin (ARB_MODE=1): all four ports requesting continuously, port 0 IDLE after each grant
//     -> grants 1,2,3,0,1 on successive HREADYM cycles.
//  T4 Burst hold: port 2 issues INCR8 NONSEQ + 7 SEQ while port 0 requests
//     -> addr_in_port stays 2 for all 8 beats, burst_hold=1 during them;
//     -> port 0 granted on the first update after the last SEQ.
//  T5 Early termination and wait states: INCR4 NONSEQ, then IDLE after 1 SEQ -> counter clears,
//     re-arbitration in that cycle; HREADYM=0 for 3 cycles mid-burst -> no state change.
//  T6 Lock and reset mid-burst: HMASTLOCKM=1 with a higher-priority req -> grant unchanged;
//     HRESET=1 during an INCR16 -> reset values next cycle.

Source files
------------

// File: rtl/ahbmtx_arb_param.sv
// Output-stage arbiter for one shared slave port of the AHB bus matrix.
// Fixed-priority or round-robin selection, with optional grant hold for defined-length bursts.
module ahbmtx_arb_param #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned PORT_W     = 3,
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned BURST_HOLD = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned NSLOT = 1 << PORT_W;

    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_NSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    logic [PORT_W-1:0] port_q, port_d;
    logic [PORT_W-1:0] ptr_q, ptr_d;
    logic              no_port_q, no_port_d;
    logic              hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NSLOT-1:0]  cand;
    logic              grant_vld;
    logic [PORT_W-1:0] grant_idx;
    logic              hold_act;
    logic [CNT_W-1:0]  beats_m1;

    // Requesters plus the current owner while it is still mid-transfer.
    always_comb begin
        cand = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            cand[PORT_W'(i)] = req_port[i]
                             | ((port_q == PORT_W'(i)) & HSELM & (HTRANSM != TR_IDLE) & ~no_port_q);
        end
    end

    // Winner search: lowest index wins, or rotate from the slot after the last grant.
    always_comb begin
        int unsigned idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (ARB_MODE == 0) begin
            for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
                if (cand[PORT_W'(i)]) begin
                    grant_vld = 1'b1;
                    grant_idx = PORT_W'(i);
                end
            end
        end else begin
            for (int k = int'(NUM_PORTS); k >= 1; k--) begin
                idx = 32'(ptr_q) + 32'(k);
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (cand[PORT_W'(idx)]) begin
                    grant_vld = 1'b1;
                    grant_idx = PORT_W'(idx);
                end
            end
        end
    end

    // Remaining beats after the NONSEQ of a defined-length burst.
    always_comb begin
        beats_m1 = '0;
        case (HBURSTM)
            3'b010, 3'b011: beats_m1 = CNT_W'(3);
            3'b100, 3'b101: beats_m1 = CNT_W'(7);
            3'b110, 3'b111: beats_m1 = CNT_W'(15);
            default:        beats_m1 = '0;
        endcase
    end

    // IDLE or NONSEQ mid-burst is an early termination and releases the hold.
    assign hold_act = (BURST_HOLD != 0) && (cnt_q != '0)
                   && ((HTRANSM == TR_SEQ) || (HTRANSM == TR_BUSY));

    always_comb begin
        port_d    = port_q;
        ptr_d     = ptr_q;
        no_port_d = no_port_q;
        cnt_d     = cnt_q;
        if (HREADYM) begin
            if (!HMASTLOCKM) begin
                if (hold_act) begin
                    no_port_d = 1'b0;
                end else if (grant_vld) begin
                    port_d    = grant_idx;
                    ptr_d     = grant_idx;
                    no_port_d = 1'b0;
                end else if (HSELM) begin
                    no_port_d = 1'b0;
                end else begin
                    no_port_d = 1'b1;
                end
            end
            if (BURST_HOLD != 0) begin
                if ((HTRANSM == TR_NSEQ) && HSELM) begin
                    cnt_d = beats_m1;
                end else if ((HTRANSM == TR_IDLE) || (HTRANSM == TR_NSEQ)) begin
                    cnt_d = '0;
                end else if ((HTRANSM == TR_SEQ) && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
        hold_d = (cnt_d != '0);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            port_q    <= '0;
            ptr_q     <= '0;
            no_port_q <= 1'b1;
            hold_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            port_q    <= port_d;
            ptr_q     <= ptr_d;
            no_port_q <= no_port_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
        end
    end

    assign addr_in_port = port_q;
    assign no_port      = no_port_q;
    assign burst_hold   = hold_q;

endmodule

// File: tb/tb_ahbmtx_arb_param.sv
// Bench for ahbmtx_arb_param: a fixed-priority and a round-robin instance share stimulus
// and are checked against a transaction-level reference model.
module tb_ahbmtx_arb_param;

    localparam int NP = 4;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;

    logic [2:0] a_f, a_r;
    logic       no_f, no_r, bh_f, bh_r;

    int total = 0;
    int bad   = 0;

    // Reference state: index 0 = fixed-priority instance, 1 = round-robin instance.
    int mp[2]   = '{0, 0};
    int mn[2]   = '{1, 1};
    int mlast[2] = '{0, 0};
    int mleft   = 0;

    always #5 HCLK = ~HCLK;

    ahbmtx_arb_param #(.NUM_PORTS(4), .PORT_W(3), .ARB_MODE(0), .BURST_HOLD(1)) u_fix (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(a_f), .no_port(no_f), .burst_hold(bh_f)
    );

    ahbmtx_arb_param #(.NUM_PORTS(4), .PORT_W(3), .ARB_MODE(1), .BURST_HOLD(1)) u_rr (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(a_r), .no_port(no_r), .burst_hold(bh_r)
    );

    task automatic model_update();
        int  pick;
        int  idx;
        int  len;
        bit  hold;
        bit  c;
        if (HRESET) begin
            for (int m = 0; m < 2; m++) begin
                mp[m] = 0; mn[m] = 1; mlast[m] = 0;
            end
            mleft = 0;
            return;
        end
        if (!HREADYM) return;
        hold = (mleft > 0) && (HTRANSM == 2'b11 || HTRANSM == 2'b01);
        for (int m = 0; m < 2; m++) begin
            if (HMASTLOCKM) continue;
            if (hold) begin
                mn[m] = 0;
                continue;
            end
            pick = -1;
            for (int k = 1; k <= NP; k++) begin
                idx = (m == 0) ? (k - 1) : ((mlast[m] + k) % NP);
                c = req_port[idx[1:0]]
                    || (idx == mp[m] && HSELM && HTRANSM != 2'b00 && mn[m] == 0);
                if (c && pick < 0) pick = idx;
            end
            if (pick >= 0) begin
                mp[m] = pick; mn[m] = 0; mlast[m] = pick;
            end else if (HSELM) begin
                mn[m] = 0;
            end else begin
                mn[m] = 1;
            end
        end
        if (HTRANSM == 2'b10 && HSELM) begin
            len   = (HBURSTM < 3'd2) ? 1 : (2 << (HBURSTM >> 1));
            mleft = len - 1;
        end else if (HTRANSM == 2'b00 || HTRANSM == 2'b10) begin
            mleft = 0;
        end else if (HTRANSM == 2'b11 && mleft > 0) begin
            mleft = mleft - 1;
        end
    endtask

    function automatic logic [4:0] exp_vec(input int m);
        return {3'(mp[m]), 1'(mn[m]), (mleft > 0)};
    endfunction

    task automatic tick();
        @(posedge HCLK);
        model_update();
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic sel, input logic [1:0] tr,
                         input logic [2:0] burst);
        req_port = req; HSELM = sel; HTRANSM = tr; HBURSTM = burst;
    endtask

    task automatic do_reset();
        HRESET = 1'b1; HREADYM = 1'b1; HMASTLOCKM = 1'b0;
        drive(4'b0000, 1'b0, 2'b00, 3'b000);
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; HREADYM = 1'b1; HMASTLOCKM = 1'b0;
        drive(4'b1111, 1'b1, 2'b10, 3'b111);
        tick();
        tick();
        total++;
        if ({a_f, no_f, bh_f} !== 5'b000_1_0) begin
            bad++; $display("FAIL reset_fix got=%b exp=%b", {a_f, no_f, bh_f}, 5'b000_1_0);
        end
        total++;
        if ({a_r, no_r, bh_r} !== 5'b000_1_0) begin
            bad++; $display("FAIL reset_rr got=%b exp=%b", {a_r, no_r, bh_r}, 5'b000_1_0);
        end
        HRESET = 1'b0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        drive(4'b1010, 1'b0, 2'b00, 3'b000);
        tick();
        total++;
        if ({a_f, no_f} !== 4'b001_0) begin
            bad++; $display("FAIL fixed_first got=%b exp=%b", {a_f, no_f}, 4'b001_0);
        end
        drive(4'b1000, 1'b0, 2'b00, 3'b000);
        tick();
        total++;
        if ({a_f, no_f} !== 4'b011_0) begin
            bad++; $display("FAIL fixed_second got=%b exp=%b", {a_f, no_f}, 4'b011_0);
        end
        drive(4'b0000, 1'b0, 2'b00, 3'b000);
        tick();
        total++;
        if ({a_f, no_f} !== 4'b011_1) begin
            bad++; $display("FAIL fixed_none got=%b exp=%b", {a_f, no_f}, 4'b011_1);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{1, 2, 3, 0, 1};
        do_reset();
        drive(4'b1111, 1'b0, 2'b00, 3'b000);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({a_r, no_r} !== {3'(exp_seq[i]), 1'b0}) begin
                bad++;
                $display("FAIL rr_seq[%0d] got=%0d/%b exp=%0d/0", i, a_r, no_r, exp_seq[i]);
            end
        end
    endtask

    task automatic test_burst_hold();
        do_reset();
        drive(4'b0100, 1'b0, 2'b00, 3'b000);
        tick();
        drive(4'b0100, 1'b1, 2'b10, 3'b101);
        tick();
        total++;
        if ({a_f, no_f, bh_f} !== 5'b010_0_1) begin
            bad++; $display("FAIL hold_start got=%b exp=%b", {a_f, no_f, bh_f}, 5'b010_0_1);
        end
        for (int k = 1; k <= 7; k++) begin
            drive(4'b0101, 1'b1, 2'b11, 3'b101);
            tick();
            total++;
            if ({a_f, bh_f} !== {3'd2, (k < 7)}) begin
                bad++; $display("FAIL hold_seq[%0d] got=%0d/%b exp=2/%b", k, a_f, bh_f, (k < 7));
            end
        end
        drive(4'b0101, 1'b0, 2'b00, 3'b000);
        tick();
        total++;
        if ({a_f, no_f, bh_f} !== 5'b000_0_0) begin
            bad++; $display("FAIL hold_release got=%b exp=%b", {a_f, no_f, bh_f}, 5'b000_0_0);
        end
    endtask

    task automatic test_early_term();
        do_reset();
        drive(4'b0010, 1'b0, 2'b00, 3'b000);
        tick();
        drive(4'b0010, 1'b1, 2'b10, 3'b011);
        tick();
        drive(4'b0010, 1'b1, 2'b11, 3'b011);
        tick();
        total++;
        if ({a_f, no_f, bh_f} !== 5'b001_0_1) begin
            bad++; $display("FAIL et_mid got=%b exp=%b", {a_f, no_f, bh_f}, 5'b001_0_1);
        end
        HREADYM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 1'b0, 2'b00, 3'b000);
            tick();
            total++;
            if ({a_f, no_f, bh_f} !== 5'b001_0_1) begin
                bad++; $display("FAIL et_wait[%0d] got=%b exp=%b", i, {a_f, no_f, bh_f}, 5'b001_0_1);
            end
        end
        HREADYM = 1'b1;
        tick();
        total++;
        if ({a_f, no_f, bh_f} !== 5'b000_0_0) begin
            bad++; $display("FAIL et_rearb got=%b exp=%b", {a_f, no_f, bh_f}, 5'b000_0_0);
        end
    endtask

    task automatic test_lock_reset();
        do_reset();
        drive(4'b0100, 1'b0, 2'b00, 3'b000);
        tick();
        drive(4'b0100, 1'b1, 2'b10, 3'b111);
        tick();
        HMASTLOCKM = 1'b1;
        drive(4'b0001, 1'b1, 2'b11, 3'b111);
        tick();
        total++;
        if ({a_f, no_f, bh_f} !== 5'b010_0_1) begin
            bad++; $display("FAIL lock_seq got=%b exp=%b", {a_f, no_f, bh_f}, 5'b010_0_1);
        end
        drive(4'b0001, 1'b0, 2'b00, 3'b000);
        tick();
        total++;
        if ({a_f, no_f, bh_f} !== 5'b010_0_0) begin
            bad++; $display("FAIL lock_idle got=%b exp=%b", {a_f, no_f, bh_f}, 5'b010_0_0);
        end
        HMASTLOCKM = 1'b0;
        drive(4'b0100, 1'b1, 2'b10, 3'b111);
        tick();
        drive(4'b0101, 1'b1, 2'b11, 3'b111);
        tick();
        HRESET = 1'b1;
        tick();
        total++;
        if ({a_f, no_f, bh_f} !== 5'b000_1_0) begin
            bad++; $display("FAIL rst_mid got=%b exp=%b", {a_f, no_f, bh_f}, 5'b000_1_0);
        end
        HRESET = 1'b0;
        drive(4'b0001, 1'b1, 2'b11, 3'b111);
        tick();
        total++;
        if ({a_f, no_f, bh_f} !== 5'b000_0_0) begin
            bad++; $display("FAIL rst_nohold got=%b exp=%b", {a_f, no_f, bh_f}, 5'b000_0_0);
        end
    endtask

    task automatic test_random();
        logic [1:0] tr;
        for (int n = 0; n < 800; n++) begin
            HRESET     = ($urandom_range(0, 99) < 2);
            HREADYM    = ($urandom_range(0, 3) != 0);
            HMASTLOCKM = ($urandom_range(0, 9) == 0);
            HSELM      = ($urandom_range(0, 3) != 0);
            tr         = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) tr = 2'b11;
            HTRANSM    = tr;
            HBURSTM    = 3'($urandom_range(0, 7));
            req_port   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            tick();
            total++;
            if ({a_f, no_f, bh_f} !== exp_vec(0)) begin
                bad++; $display("FAIL rand_fix n=%0d got=%b exp=%b", n, {a_f, no_f, bh_f}, exp_vec(0));
            end
            total++;
            if ({a_r, no_r, bh_r} !== exp_vec(1)) begin
                bad++; $display("FAIL rand_rr n=%0d got=%b exp=%b", n, {a_r, no_r, bh_r}, exp_vec(1));
            end
        end
    endtask

    initial begin
        HRESET = 1'b1; HREADYM = 1'b1; HMASTLOCKM = 1'b0;
        drive(4'b0000, 1'b0, 2'b00, 3'b000);
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_burst_hold();
        test_early_term();
        test_lock_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
